dlx_mem_initiator: RTL

- CPU-side master for the testbench memory bus: drives ADDRESS, ENABLE, READNOTWRITE and INOUT_DATA, and waits for DATA_READY from the memory model.
- Converts a single-beat valid/ready request from the DLX datapath into one bus transaction and returns read data or an error as a one-cycle response pulse.
- Enforces a return-to-idle phase between transactions and a timeout watchdog, so a hung memory model is reported instead of stalling the core.

---
 rtl/dlx_mem_initiator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dlx_mem_initiator.sv
// CPU-side bus master: turns one valid/ready request into a single ENABLE/DATA_READY
// transaction, with a return-to-idle phase and a timeout watchdog.
module dlx_mem_initiator #(
  parameter int ADDRESS_SIZE   = 16,
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic                    req_we,
  input  logic [WORD_SIZE-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [WORD_SIZE-1:0]    resp_rdata,
  output logic                    resp_err,
  output logic [ADDRESS_SIZE-1:0] ADDRESS,
  output logic                    ENABLE,
  output logic                    READNOTWRITE,
  input  logic                    DATA_READY,
  inout  wire  [WORD_SIZE-1:0]    INOUT_DATA
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    we_q, we_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic                    drive_q, drive_d;
  logic                    enable_d;
  logic [ADDRESS_SIZE-1:0] addr_d;
  logic                    rnw_d;
  logic                    rv_d;
  logic [WORD_SIZE-1:0]    rdata_d;
  logic                    err_d;
  logic                    timeout_hit;

  assign req_ready   = (state_q == IDLE) && !rst;
  assign INOUT_DATA  = drive_q ? wdata_q : 'z;
  assign timeout_hit = TIMEOUT_EN && (timer_q == TLAST);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    drive_d  = drive_q;
    enable_d = ENABLE;
    addr_d   = ADDRESS;
    rnw_d    = READNOTWRITE;
    rv_d     = 1'b0;
    rdata_d  = resp_rdata;
    err_d    = resp_err;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = ACCESS;
          timer_d  = '0;
          we_d     = req_we;
          wdata_d  = req_wdata;
          addr_d   = req_addr;
          enable_d = 1'b1;
          rnw_d    = ~req_we;
          drive_d  = req_we;
        end
      end
      ACCESS: begin
        // Completion takes priority over an expiring watchdog on the same edge.
        if (DATA_READY || timeout_hit) begin
          if (DATA_READY && !we_q) rdata_d = INOUT_DATA;
          rv_d     = 1'b1;
          err_d    = !DATA_READY;
          state_d  = RELEASE;
          enable_d = 1'b0;
          drive_d  = 1'b0;
          rnw_d    = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELEASE: begin
        // A DATA_READY left high by the previous access must drop before reuse.
        if (!DATA_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      drive_q      <= 1'b0;
      ENABLE       <= 1'b0;
      ADDRESS      <= '0;
      READNOTWRITE <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      drive_q      <= drive_d;
      ENABLE       <= enable_d;
      ADDRESS      <= addr_d;
      READNOTWRITE <= rnw_d;
      resp_valid   <= rv_d;
      resp_rdata   <= rdata_d;
      resp_err     <= err_d;
    end
  end

endmodule
